// File: rtl/capture_ram_ctrl.sv
// Capture buffer: arm, fill DEPTH words of multi-channel samples, then read them back out in order.
// Optional build macro CAPTURE_OVF_CNT_EN adds o_ovf_count (samples offered while the buffer is full).
module capture_ram_ctrl #(
    parameter int NB_DATA = 14,
    parameter int NB_CH   = 1,
    parameter int NB_ADDR = 11
) (
    input  logic                     clock,
    input  logic                     i_reset,
    input  logic                     i_arm,
    input  logic                     i_valid,
    input  logic [NB_CH*NB_DATA-1:0] i_data,
    input  logic                     i_read_enable,
    output logic [NB_CH*NB_DATA-1:0] o_data,
    output logic                     o_data_valid,
    output logic                     o_full,
    output logic                     o_empty,
`ifdef CAPTURE_OVF_CNT_EN
    output logic [1:0]               o_state,
    output logic [15:0]              o_ovf_count
`else
    output logic [1:0]               o_state
`endif
);

    localparam int                 NB_WORD   = NB_CH * NB_DATA;
    localparam int                 DEPTH     = 2 ** NB_ADDR;
    localparam logic [NB_ADDR-1:0] ADDR_ZERO = {NB_ADDR{1'b0}};
    localparam logic [NB_ADDR-1:0] ADDR_LAST = {NB_ADDR{1'b1}};
    localparam logic [NB_ADDR-1:0] ADDR_ONE  = NB_ADDR'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2,
        ST_UNUSED  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [NB_ADDR-1:0] wr_ptr_r;
    logic [NB_ADDR-1:0] wr_ptr_s;
    logic [NB_ADDR-1:0] rd_ptr_r;
    logic [NB_ADDR-1:0] rd_ptr_s;
    logic               arm_q_r;
    logic               arm_edge_s;
    logic               wr_en_s;
    logic               rd_en_s;
    logic               to_capture_s;
    logic               full_r;
    logic               empty_r;

    logic [NB_WORD-1:0] mem_r [DEPTH];
    logic [NB_WORD-1:0] rd_word_r;
    logic               rd_pend_r;
    logic [NB_WORD-1:0] o_data_r;
    logic               o_data_valid_r;

    // arm_q resets high so an arm level held through reset is not seen as an edge
    assign arm_edge_s = i_arm & ~arm_q_r;

    // Next-state, pointer and memory-strobe decode
    always_comb begin
        state_s      = state_r;
        wr_ptr_s     = wr_ptr_r;
        rd_ptr_s     = rd_ptr_r;
        wr_en_s      = 1'b0;
        rd_en_s      = 1'b0;
        to_capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arm_edge_s) begin
                    state_s      = ST_CAPTURE;
                    wr_ptr_s     = ADDR_ZERO;
                    to_capture_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (i_valid) begin
                    wr_en_s  = 1'b1;
                    wr_ptr_s = wr_ptr_r + ADDR_ONE;
                    if (wr_ptr_r == ADDR_LAST) begin
                        state_s  = ST_FULL;
                        rd_ptr_s = ADDR_ZERO;
                    end else begin
                        state_s = ST_CAPTURE;
                    end
                end else begin
                    state_s = ST_CAPTURE;
                end
            end
            ST_FULL: begin
                // A new arm discards whatever is still unread, even with a read pending
                if (arm_edge_s) begin
                    state_s      = ST_CAPTURE;
                    wr_ptr_s     = ADDR_ZERO;
                    to_capture_s = 1'b1;
                end else if (i_read_enable) begin
                    rd_en_s  = 1'b1;
                    rd_ptr_s = rd_ptr_r + ADDR_ONE;
                    if (rd_ptr_r == ADDR_LAST) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_FULL;
                    end
                end else begin
                    state_s = ST_FULL;
                end
            end
            ST_UNUSED: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, pointers, arm history and registered status flags
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_r  <= ST_IDLE;
            wr_ptr_r <= ADDR_ZERO;
            rd_ptr_r <= ADDR_ZERO;
            arm_q_r  <= 1'b1;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            state_r  <= state_s;
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            arm_q_r  <= i_arm;
            full_r   <= (state_s == ST_FULL);
            empty_r  <= (state_s == ST_IDLE);
        end
    end

    // Sample memory with a registered read port; contents survive reset
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= i_data;
        end
        if (rd_en_s) begin
            rd_word_r <= mem_r[rd_ptr_r];
        end
    end

    // Output stage: readout word and its one-cycle valid strobe
    always_ff @(posedge clock) begin
        if (i_reset) begin
            rd_pend_r      <= 1'b0;
            o_data_r       <= {NB_WORD{1'b0}};
            o_data_valid_r <= 1'b0;
        end else begin
            rd_pend_r      <= rd_en_s;
            o_data_valid_r <= rd_pend_r;
            if (rd_pend_r) begin
                o_data_r <= rd_word_r;
            end
        end
    end

    assign o_data       = o_data_r;
    assign o_data_valid = o_data_valid_r;
    assign o_full       = full_r;
    assign o_empty      = empty_r;
    assign o_state      = state_r;

`ifdef CAPTURE_OVF_CNT_EN
    logic [15:0] ovf_cnt_r;

    // Saturating count of samples dropped while a capture waits to be read
    always_ff @(posedge clock) begin
        if (i_reset) begin
            ovf_cnt_r <= 16'h0000;
        end else if (to_capture_s) begin
            ovf_cnt_r <= 16'h0000;
        end else if ((state_r == ST_FULL) && i_valid && (ovf_cnt_r != 16'hFFFF)) begin
            ovf_cnt_r <= ovf_cnt_r + 16'h0001;
        end else begin
            ovf_cnt_r <= ovf_cnt_r;
        end
    end

    assign o_ovf_count = ovf_cnt_r;
`endif

endmodule

// File: doc/capture_ram_ctrl.md
CAPTURE_RAM_CTRL -- requirements
Module: capture_ram_ctrl

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 14, meaning the sample width per channel in bits.
REQ-002 The block SHALL have parameter NB_CH, default 1, meaning the number of channels stored side by side in each memory word.
REQ-003 The block SHALL have parameter NB_ADDR, default 11, meaning the address width; DEPTH = 2**NB_ADDR words.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port i_arm, input, 1 bit: arm level; only its rising edge is acted on.
REQ-007 The block SHALL have port i_valid, input, 1 bit: i_data holds a sample this cycle.
REQ-008 The block SHALL have port i_data, input, NB_CH*NB_DATA bits: channel k in bits [k*NB_DATA +: NB_DATA].
REQ-009 The block SHALL have port i_read_enable, input, 1 bit: request one readout word.
REQ-010 The block SHALL have port o_data, output, NB_CH*NB_DATA bits: the readout word.
REQ-011 The block SHALL have port o_data_valid, output, 1 bit: o_data is valid this cycle.
REQ-012 The block SHALL have port o_full, output, 1 bit: buffer holds a complete capture.
REQ-013 The block SHALL have port o_empty, output, 1 bit: no capture data available.
REQ-014 The block SHALL have port o_state, output, 2 bits: current FSM state code.

Function
REQ-015 The block SHALL contain an internal DEPTH x (NB_CH*NB_DATA) simple dual-port memory with one write port and one registered read port.
REQ-016 The FSM SHALL have states IDLE=0, CAPTURE=1 and FULL=2; code 3 is unused and SHALL recover to IDLE on the next edge.
REQ-017 Arm edge: arm_edge = i_arm AND NOT arm_q, where arm_q is i_arm registered every cycle.
REQ-018 IDLE->CAPTURE on arm_edge, and wr_ptr<=0 at the same edge.
REQ-019 In CAPTURE, each cycle with i_valid=1 SHALL write i_data to mem[wr_ptr] and increment wr_ptr.
REQ-020 A CAPTURE write at wr_ptr=DEPTH-1 SHALL move the FSM to FULL and set rd_ptr<=0; wr_ptr SHALL wrap to 0.
REQ-021 In CAPTURE, arm_edge SHALL be ignored and i_read_enable SHALL be ignored (no o_data_valid).
REQ-022 In FULL, i_read_enable=1 at edge k SHALL read mem[rd_ptr] and increment rd_ptr.
REQ-023 For the read in REQ-022, o_data SHALL present mem[rd_ptr] and o_data_valid=1 for exactly one cycle after edge k+1 (read latency 1).
REQ-024 A FULL read at rd_ptr=DEPTH-1 SHALL move the FSM to IDLE after that edge; its o_data_valid still follows on the next cycle.
REQ-025 arm_edge in FULL SHALL discard unread data and enter CAPTURE with wr_ptr<=0; if i_read_enable is also 1 that cycle, arm wins and no read occurs.
REQ-026 In FULL, i_valid SHALL be ignored (no write).
REQ-027 Outputs: o_full=1 iff state=FULL; o_empty=1 iff state=IDLE; o_state equals the state code.
REQ-028 o_data SHALL hold its last value when o_data_valid=0.
REQ-029 Pointers SHALL be NB_ADDR bits wide and wrap modulo DEPTH.

Reset
REQ-030 i_reset=1 at an edge SHALL force state=IDLE, wr_ptr=0, rd_ptr=0, arm_q=1, o_data=0 and o_data_valid=0, and SHALL take priority over all other inputs in any state.
REQ-031 arm_q=1 at reset SHALL prevent an i_arm level held high through reset from causing an arm_edge.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-033 With macro CAPTURE_OVF_CNT_EN defined, the block SHALL add port o_ovf_count, output, 16 bits.
REQ-034 o_ovf_count SHALL count cycles with i_valid=1 in state FULL.
REQ-035 o_ovf_count SHALL saturate at 16'hFFFF.
REQ-036 o_ovf_count SHALL clear on i_reset and on every IDLE->CAPTURE or FULL->CAPTURE transition.
REQ-037 Without CAPTURE_OVF_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification (NB_ADDR=3, NB_CH=2, NB_DATA=8)
REQ-038 Reset with i_arm held at 1, then 20 cycles -> state stays 0, o_empty=1, no capture starts.
REQ-039 Arm edge, then 8 i_valid samples {ch1=0x10+n, ch0=n} with gaps -> o_full=1 after the 8th write only.
REQ-040 Eight i_read_enable pulses -> o_data 0x1000..0x1707 in order, each one cycle later, then o_empty=1.
REQ-041 Read 3 words, then arm edge with i_read_enable=1 -> no 4th o_data_valid, state=1, next write goes to address 0.
REQ-042 i_reset asserted mid-CAPTURE after 5 writes -> state=0 next cycle; a fresh arm yields a capture starting at address 0.
REQ-043 With CAPTURE_OVF_CNT_EN, 5 i_valid cycles while FULL -> o_ovf_count=5; the next arm edge -> 0.
